ucie_ctl_stack_mux_tx: RTL and testbench

Multi-stack FDI-to-RDI transmit mux for the adapter datapath. It generalises the single-stack TX FIFO to NSTACKS protocol stacks, each with its own per-stack FIFO, and feeds one shared RDI main-band transmit port through a registered output stage. Arbitration is round-robin or weighted round-robin. The block sits between the per-stack FDI transmit interfaces and the PHY RDI lp_data/lp_valid/lp_irdy port.

---
 rtl/ucie_ctl_stack_pkg.sv | 28 ++
 rtl/ucie_ctl_stack_fifo.sv | 50 +++++
 rtl/ucie_ctl_stack_mux_tx.sv | 141 ++++++++++++++
 tb/tb_ucie_ctl_stack_mux_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_stack_pkg.sv
// Shared definitions for the multi-stack FDI-to-RDI transmit mux:
// FDI state encodings, arbitration modes and small sizing helpers.
package ucie_ctl_stack_pkg;

    localparam logic [3:0] ST_RESET     = 4'h0;
    localparam logic [3:0] ST_ACTIVE    = 4'h1;
    localparam logic [3:0] ST_L1        = 4'h4;
    localparam logic [3:0] ST_L2        = 4'h8;
    localparam logic [3:0] ST_LINKRESET = 4'h9;
    localparam logic [3:0] ST_LINKERROR = 4'hA;
    localparam logic [3:0] ST_RETRAIN   = 4'hB;
    localparam logic [3:0] ST_DISABLED  = 4'hC;

    typedef enum logic {
        ARB_RR  = 1'b0,
        ARB_WRR = 1'b1
    } arb_mode_e;

    function automatic int sid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // States in which queued transmit data is discarded rather than held
    function automatic logic is_flush_state(input logic [3:0] state);
        return (state == ST_LINKRESET) || (state == ST_LINKERROR) || (state == ST_DISABLED);
    endfunction

endpackage

// File: rtl/ucie_ctl_stack_fifo.sv
// Per-stack transmit FIFO with extra-MSB pointers, show-ahead head output
// and a synchronous flush that empties the queue.
module ucie_ctl_stack_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head_data = mem[rd_ptr_reg[AW-1:0]];

    // Flush overrides any simultaneous pop; the popped head is still consumed by the caller
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full)
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ucie_ctl_stack_mux_tx.sv
// Multi-stack FDI transmit mux: per-stack FIFOs, round-robin or weighted
// round-robin arbitration, and one registered RDI output stage.
module ucie_ctl_stack_mux_tx
    import ucie_ctl_stack_pkg::*;
#(
    parameter int  NBYTES     = 64,
    parameter int  NSTACKS    = 2,
    parameter int  FIFO_DEPTH = 4,
    parameter int  ARB_MODE   = 0,
    parameter int  WEIGHT_W   = 4,
    localparam int DW         = NBYTES * 8,
    localparam int SID_W      = sid_w(NSTACKS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [4*NSTACKS-1:0]      i_fdi_pl_state_sts,
    input  logic [NSTACKS-1:0]        i_fdi_lp_valid,
    input  logic [NSTACKS-1:0]        i_fdi_lp_irdy,
    input  logic [NSTACKS*DW-1:0]     i_fdi_lp_data,
    output logic [NSTACKS-1:0]        o_fdi_pl_trdy,
    input  logic [NSTACKS*WEIGHT_W-1:0] i_weight,
    input  logic                      i_err_clr,
    input  logic                      i_rdi_pl_trdy,
    output logic                      o_rdi_lp_valid,
    output logic                      o_rdi_lp_irdy,
    output logic [DW-1:0]             o_rdi_lp_data,
    output logic [SID_W-1:0]          o_rdi_lp_stack_id,
    output logic [NSTACKS-1:0]        o_drop_err,
    output logic                      o_idle
);

    logic [NSTACKS-1:0] fifo_full;
    logic [NSTACKS-1:0] fifo_empty;
    logic [NSTACKS-1:0] fifo_push;
    logic [NSTACKS-1:0] fifo_pop;
    logic [NSTACKS-1:0] fifo_flush;
    logic [NSTACKS-1:0] drop_set;
    logic [DW-1:0]      head_data [NSTACKS];

    logic [NSTACKS-1:0]  drop_err_reg;
    logic [SID_W-1:0]    ptr_reg;
    logic [WEIGHT_W-1:0] burst_cnt_reg;
    logic [WEIGHT_W-1:0] burst_lim_reg;
    logic                out_valid_reg;
    logic [DW-1:0]       out_data_reg;
    logic [SID_W-1:0]    out_sid_reg;

    logic                any_ready;
    logic                load;
    logic                keep;
    logic                found;
    logic [SID_W-1:0]    rr_win;
    logic [SID_W-1:0]    win;
    logic [WEIGHT_W-1:0] win_weight;

    generate
        for (genvar gi = 0; gi < NSTACKS; gi++) begin : g_stack
            logic [3:0] state;
            logic       active;

            assign state             = i_fdi_pl_state_sts[4*gi +: 4];
            assign active            = (state == ST_ACTIVE);
            assign o_fdi_pl_trdy[gi] = active & ~fifo_full[gi];
            assign fifo_push[gi]     = i_fdi_lp_valid[gi] & i_fdi_lp_irdy[gi] & o_fdi_pl_trdy[gi];
            assign drop_set[gi]      = i_fdi_lp_valid[gi] & i_fdi_lp_irdy[gi] & ~active;
            assign fifo_flush[gi]    = is_flush_state(state);
            assign fifo_pop[gi]      = load & (win == SID_W'(gi));

            ucie_ctl_stack_fifo #(
                .WIDTH (DW),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (i_clk),
                .rst       (i_rst),
                .push      (fifo_push[gi]),
                .push_data (i_fdi_lp_data[gi*DW +: DW]),
                .pop       (fifo_pop[gi]),
                .flush     (fifo_flush[gi]),
                .head_data (head_data[gi]),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty[gi])
            );
        end
    endgenerate

    // Round-robin search starting just after the last winner
    always_comb begin
        found  = 1'b0;
        rr_win = ptr_reg;
        for (int k = 1; k <= NSTACKS; k++) begin
            if (!found && !fifo_empty[(int'(ptr_reg) + k) % NSTACKS]) begin
                found  = 1'b1;
                rr_win = SID_W'((int'(ptr_reg) + k) % NSTACKS);
            end
        end
    end

    // In weighted mode the current holder keeps the grant until its burst is spent or it runs dry
    assign keep       = (ARB_MODE == int'(ARB_WRR)) && !fifo_empty[ptr_reg] &&
                        (burst_cnt_reg < burst_lim_reg);
    assign win        = keep ? ptr_reg : rr_win;
    assign win_weight = i_weight[int'(win)*WEIGHT_W +: WEIGHT_W];
    assign any_ready  = ~&fifo_empty;
    assign load       = (~out_valid_reg | i_rdi_pl_trdy) & any_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_reg       <= SID_W'(NSTACKS - 1);
            burst_cnt_reg <= '0;
            burst_lim_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sid_reg   <= '0;
            drop_err_reg  <= '0;
        end else begin
            drop_err_reg <= (drop_err_reg & ~{NSTACKS{i_err_clr}}) | drop_set;
            if (load) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= head_data[win];
                out_sid_reg   <= win;
                ptr_reg       <= win;
                if (keep) begin
                    burst_cnt_reg <= burst_cnt_reg + WEIGHT_W'(1);
                end else begin
                    burst_cnt_reg <= WEIGHT_W'(1);
                    burst_lim_reg <= (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
                end
            end else if (i_rdi_pl_trdy) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign o_rdi_lp_valid    = out_valid_reg;
    assign o_rdi_lp_irdy     = out_valid_reg;
    assign o_rdi_lp_data     = out_data_reg;
    assign o_rdi_lp_stack_id = out_sid_reg;
    assign o_drop_err        = drop_err_reg;
    assign o_idle            = &fifo_empty & ~out_valid_reg;

endmodule

// File: tb/tb_ucie_ctl_stack_mux_tx.sv
// Directed bench for the multi-stack TX mux: a vector table for RR ordering
// and drop errors, plus sequences for backpressure, WRR, flush and reset.
module tb_ucie_ctl_stack_mux_tx;

    localparam int NS = 2;
    localparam int DW = 16;
    localparam logic [3:0] A  = 4'h1;
    localparam logic [3:0] L1 = 4'h4;
    localparam logic [3:0] LR = 4'h9;
    localparam logic [3:0] RT = 4'hB;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*NS-1:0]  st;
    logic [NS-1:0]    v;
    logic [NS*DW-1:0] d;
    logic [NS*4-1:0]  weight;
    logic          err_clr;
    logic          rtrdy;

    logic [NS-1:0] rr_trdy, wr_trdy, rr_drop, wr_drop;
    logic          rr_val, rr_irdy, rr_sid, rr_idle;
    logic          wr_val, wr_irdy, wr_sid, wr_idle;
    logic [DW-1:0] rr_data, wr_data;

    int n_checks = 0;
    int n_errors = 0;

    ucie_ctl_stack_mux_tx #(.NBYTES(2), .NSTACKS(NS), .FIFO_DEPTH(4), .ARB_MODE(0), .WEIGHT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_fdi_pl_state_sts(st), .i_fdi_lp_valid(v), .i_fdi_lp_irdy(v),
        .i_fdi_lp_data(d), .o_fdi_pl_trdy(rr_trdy), .i_weight(weight), .i_err_clr(err_clr),
        .i_rdi_pl_trdy(rtrdy), .o_rdi_lp_valid(rr_val), .o_rdi_lp_irdy(rr_irdy),
        .o_rdi_lp_data(rr_data), .o_rdi_lp_stack_id(rr_sid), .o_drop_err(rr_drop), .o_idle(rr_idle));

    ucie_ctl_stack_mux_tx #(.NBYTES(2), .NSTACKS(NS), .FIFO_DEPTH(4), .ARB_MODE(1), .WEIGHT_W(4)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_fdi_pl_state_sts(st), .i_fdi_lp_valid(v), .i_fdi_lp_irdy(v),
        .i_fdi_lp_data(d), .o_fdi_pl_trdy(wr_trdy), .i_weight(weight), .i_err_clr(err_clr),
        .i_rdi_pl_trdy(rtrdy), .o_rdi_lp_valid(wr_val), .o_rdi_lp_irdy(wr_irdy),
        .o_rdi_lp_data(wr_data), .o_rdi_lp_stack_id(wr_sid), .o_drop_err(wr_drop), .o_idle(wr_idle));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st0;
        logic [3:0]  st1;
        logic [1:0]  v;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        rt;
        logic        clr;
        logic [1:0]  e_trdy;
        logic        e_val;
        logic [15:0] e_data;
        logic        e_sid;
        logic [1:0]  e_drop;
        logic        e_idle;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; v = '0; st = '0; err_clr = 1'b0; rtrdy = 1'b0; d = '0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; st = '0; v = '0; d = '0; weight = {4'd1, 4'd3}; err_clr = 1'b0; rtrdy = 1'b0;

        //            st0 st1 v      d0        d1        rt    clr   trdy   val   data      sid   drop   idle
        tbl[0]  = '{A,  A,  2'b11, 16'hA000, 16'hB000, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{A,  A,  2'b11, 16'hA001, 16'hB001, 1'b1, 1'b0, 2'b11, 1'b1, 16'hA000, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{A,  A,  2'b11, 16'hA002, 16'hB002, 1'b1, 1'b0, 2'b11, 1'b1, 16'hB000, 1'b1, 2'b00, 1'b0};
        tbl[3]  = '{A,  A,  2'b11, 16'hA003, 16'hB003, 1'b1, 1'b0, 2'b11, 1'b1, 16'hA001, 1'b0, 2'b00, 1'b0};
        tbl[4]  = '{A,  A,  2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, 1'b1, 16'hB001, 1'b1, 2'b00, 1'b0};
        tbl[5]  = '{A,  A,  2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, 1'b1, 16'hA002, 1'b0, 2'b00, 1'b0};
        tbl[6]  = '{A,  A,  2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, 1'b1, 16'hB002, 1'b1, 2'b00, 1'b0};
        tbl[7]  = '{A,  A,  2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, 1'b1, 16'hA003, 1'b0, 2'b00, 1'b0};
        tbl[8]  = '{A,  A,  2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, 1'b1, 16'hB003, 1'b1, 2'b00, 1'b0};
        tbl[9]  = '{A,  A,  2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b1};
        tbl[10] = '{A,  LR, 2'b10, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b01, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b1};
        tbl[11] = '{A,  LR, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b01, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b1};
        tbl[12] = '{A,  LR, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 2'b01, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b1};
        tbl[13] = '{A,  LR, 2'b10, 16'h0000, 16'h0000, 1'b1, 1'b1, 2'b01, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b1};
        tbl[14] = '{A,  A,  2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b11, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b1};
        tbl[15] = '{L1, A,  2'b01, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0000, 1'b0, 2'b11, 1'b1};
        tbl[16] = '{A,  A,  2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 2'b11, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b1};

        // Reset values, sampled mid-cycle while reset is held
        #12;
        chk("rst_valid", rr_val, 0);
        chk("rst_irdy", rr_irdy, 0);
        chk("rst_data", rr_data, 0);
        chk("rst_sid", rr_sid, 0);
        chk("rst_trdy", rr_trdy, 0);
        chk("rst_drop", rr_drop, 0);
        chk("rst_idle", rr_idle, 1);
        chk("rst_w_valid", wr_val, 0);
        cyc();
        rst = 1'b0;

        // Table: RR ordering, 2-cycle latency, drop error set/hold/clear
        for (int i = 0; i < 17; i++) begin
            st = {tbl[i].st1, tbl[i].st0};
            v = tbl[i].v;
            d = {tbl[i].d1, tbl[i].d0};
            rtrdy = tbl[i].rt;
            err_clr = tbl[i].clr;
            cyc();
            chk($sformatf("v%0d_trdy", i), rr_trdy, tbl[i].e_trdy);
            chk($sformatf("v%0d_valid", i), rr_val, tbl[i].e_val);
            chk($sformatf("v%0d_irdy", i), rr_irdy, tbl[i].e_val);
            if (tbl[i].e_val) begin
                chk($sformatf("v%0d_data", i), rr_data, tbl[i].e_data);
                chk($sformatf("v%0d_sid", i), rr_sid, tbl[i].e_sid);
            end
            chk($sformatf("v%0d_drop", i), rr_drop, tbl[i].e_drop);
            chk($sformatf("v%0d_idle", i), rr_idle, tbl[i].e_idle);
        end

        // Backpressure: 1 in output stage + 4 in FIFO, then release
        do_reset();
        st = {A, A};
        for (int k = 0; k < 5; k++) begin
            v = 2'b01; d = {16'h0000, 16'hC000 + 16'(k)};
            cyc();
            if (k == 0) chk("bp_lat_edge1", rr_val, 0);
            else chk($sformatf("bp_hold%0d", k), rr_data, 16'hC000);
        end
        chk("bp_full_trdy", rr_trdy[0], 0);
        d = {16'h0000, 16'hC005};
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("bp_stable_data%0d", k), rr_data, 16'hC000);
            chk($sformatf("bp_stable_trdy%0d", k), rr_trdy[0], 0);
        end
        rtrdy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("bp_out%0d", k), rr_data, 16'hC000 + 16'(k));
            chk($sformatf("bp_val%0d", k), rr_val, 1);
            if (k == 1) chk("bp_trdy_back", rr_trdy[0], 1);
            if (k == 2) v = 2'b00;
        end
        cyc();
        chk("bp_drained_valid", rr_val, 0);
        chk("bp_drained_idle", rr_idle, 1);

        // WRR weights 3/1 vs RR on the same stimulus
        do_reset();
        weight = {4'd1, 4'd3};
        st = {A, A}; rtrdy = 1'b1; v = 2'b11; d = {16'hB0B0, 16'hA0A0};
        cyc();
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk($sformatf("wrr31_sid%0d", k), wr_sid, (k % 4 == 3) ? 1 : 0);
            chk($sformatf("wrr31_val%0d", k), wr_val, 1);
            chk($sformatf("rr_sid%0d", k), rr_sid, k % 2);
        end

        // Weight 0 behaves as 1
        do_reset();
        weight = {4'd0, 4'd0};
        st = {A, A}; rtrdy = 1'b1; v = 2'b11; d = {16'hB0B0, 16'hA0A0};
        cyc();
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("wrr00_sid%0d", k), wr_sid, k % 2);
        end
        weight = {4'd1, 4'd3};

        // Retrain holds queued flits, which are still delivered
        do_reset();
        st = {A, A};
        for (int k = 0; k < 3; k++) begin
            v = 2'b10; d = {16'hE000 + 16'(k), 16'h0000};
            cyc();
        end
        v = 2'b00; st = {RT, A};
        cyc();
        chk("rt_trdy1", rr_trdy[1], 0);
        chk("rt_hold", rr_data, 16'hE000);
        rtrdy = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            cyc();
            chk($sformatf("rt_out%0d", k), rr_data, 16'hE000 + 16'(k));
            chk($sformatf("rt_val%0d", k), rr_val, 1);
        end
        cyc();
        chk("rt_done", rr_val, 0);

        // LinkReset flushes 3 queued flits; output stage flit still delivered
        do_reset();
        st = {A, A};
        for (int k = 0; k < 4; k++) begin
            v = 2'b10; d = {16'hF000 + 16'(k), 16'h0000};
            cyc();
        end
        v = 2'b00; st = {LR, A};
        cyc();
        chk("lr_stage_kept", rr_data, 16'hF000);
        chk("lr_not_idle", rr_idle, 0);
        rtrdy = 1'b1;
        cyc();
        chk("lr_no_more_valid", rr_val, 0);
        chk("lr_idle", rr_idle, 1);
        cyc();
        chk("lr_still_empty", rr_val, 0);
        v = 2'b10;
        cyc();
        chk("lr_drop_set", rr_drop, 2'b10);
        v = 2'b00;
        cyc();
        chk("lr_drop_sticky", rr_drop, 2'b10);
        err_clr = 1'b1;
        cyc();
        chk("lr_drop_clr", rr_drop, 2'b00);
        err_clr = 1'b0;

        // Flush coinciding with pop of the same FIFO
        do_reset();
        st = {A, A};
        for (int k = 0; k < 3; k++) begin
            v = 2'b10; d = {16'hD000 + 16'(k), 16'h0000};
            cyc();
        end
        v = 2'b00; rtrdy = 1'b1; st = {LR, A};
        cyc();
        chk("fp_popped_val", rr_val, 1);
        chk("fp_popped_data", rr_data, 16'hD001);
        chk("fp_popped_sid", rr_sid, 1);
        cyc();
        chk("fp_fifo_empty_val", rr_val, 0);
        chk("fp_fifo_empty_idle", rr_idle, 1);

        // Asynchronous reset mid-burst; next grant must go to stack 0
        do_reset();
        st = {A, A};
        for (int k = 0; k < 2; k++) begin
            v = 2'b01; d = {16'h0000, 16'h9000 + 16'(k)};
            cyc();
        end
        v = 2'b00;
        chk("mr_pre_valid", rr_val, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("mr_valid_now", rr_val, 0);
        chk("mr_idle_now", rr_idle, 1);
        chk("mr_w_valid_now", wr_val, 0);
        cyc();
        rst = 1'b0;
        st = {A, A}; v = 2'b11; d = {16'h5511, 16'h5500};
        cyc();
        v = 2'b00;
        cyc();
        chk("mr_grant_val", rr_val, 1);
        chk("mr_grant_sid", rr_sid, 0);
        chk("mr_grant_data", rr_data, 16'h5500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
